// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial word feeder with bit_en pacing and a one-cycle done pulse.
// Optional trailing even-parity bit enabled by defining SBF_PARITY_EN.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef SBF_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next, w_shifted;
    logic [CW-1:0]    r_count, w_count_next;
    logic             r_serial_out, w_serial_next;
    logic             r_serial_valid, w_valid_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;
    logic             r_load_ready, w_ready_next;
`ifdef SBF_PARITY_EN
    logic             r_parity, w_parity_next;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // The bit on serial_out is always the leading bit of the shift register.
    assign w_shifted = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_count_next  = r_count;
        w_serial_next = r_serial_out;
        w_valid_next  = r_serial_valid;
        w_busy_next   = r_busy;
        w_done_next   = r_done;
        w_ready_next  = r_load_ready;
`ifdef SBF_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (load_valid && r_load_ready) begin
                    w_state_next  = S_SHIFT;
                    w_shift_next  = load_data;
                    w_count_next  = '0;
                    w_serial_next = first_bit(load_data);
                    w_valid_next  = 1'b1;
                    w_busy_next   = 1'b1;
                    w_ready_next  = 1'b0;
                    w_done_next   = 1'b0;
`ifdef SBF_PARITY_EN
                    w_parity_next = ^load_data;
`endif
                end
            end
            S_SHIFT: begin
                if (bit_en) begin
                    if (r_count == CW'(WIDTH - 1)) begin
`ifdef SBF_PARITY_EN
                        w_state_next  = S_PARITY;
                        w_serial_next = r_parity;
`else
                        w_state_next  = S_DONE;
                        w_serial_next = 1'b0;
                        w_valid_next  = 1'b0;
                        w_busy_next   = 1'b0;
                        w_done_next   = 1'b1;
`endif
                    end else begin
                        w_count_next  = r_count + CW'(1);
                        w_shift_next  = w_shifted;
                        w_serial_next = first_bit(w_shifted);
                    end
                end
            end
`ifdef SBF_PARITY_EN
            S_PARITY: begin
                if (bit_en) begin
                    w_state_next  = S_DONE;
                    w_serial_next = 1'b0;
                    w_valid_next  = 1'b0;
                    w_busy_next   = 1'b0;
                    w_done_next   = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_next  = S_IDLE;
                w_serial_next = 1'b0;
                w_valid_next  = 1'b0;
                w_busy_next   = 1'b0;
                w_done_next   = 1'b0;
                w_ready_next  = 1'b1;
            end
            default: begin
                w_state_next  = S_IDLE;
                w_serial_next = 1'b0;
                w_valid_next  = 1'b0;
                w_busy_next   = 1'b0;
                w_done_next   = 1'b0;
                w_ready_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_shift        <= '0;
            r_count        <= '0;
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_load_ready   <= 1'b1;
`ifdef SBF_PARITY_EN
            r_parity       <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_shift        <= w_shift_next;
            r_count        <= w_count_next;
            r_serial_out   <= w_serial_next;
            r_serial_valid <= w_valid_next;
            r_busy         <= w_busy_next;
            r_done         <= w_done_next;
            r_load_ready   <= w_ready_next;
`ifdef SBF_PARITY_EN
            r_parity       <= w_parity_next;
`endif
        end
    end

    assign serial_out   = r_serial_out;
    assign serial_valid = r_serial_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign load_ready   = r_load_ready;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB/LSB order, pacing, load ignore, reset abort, WIDTH=1.
// Status vectors are {serial_out, serial_valid, busy, load_ready, done}.
module tb_serial_bit_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       bit_en = 1'b0;
    logic [7:0] ld8 = '0, ldl = '0;
    logic       ld1 = 1'b0;
    logic       lv8 = 1'b0, lvl = 1'b0, lv1 = 1'b0;
    logic       r8, so8, sv8, bz8, dn8;
    logic       rl, sol, svl, bzl, dnl;
    logic       r1, so1, sv1, bz1, dn1;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1)) dut8 (
        .clock(clock), .reset(reset), .load_data(ld8), .load_valid(lv8), .load_ready(r8),
        .bit_en(bit_en), .serial_out(so8), .serial_valid(sv8), .busy(bz8), .done(dn8));

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0)) dutl (
        .clock(clock), .reset(reset), .load_data(ldl), .load_valid(lvl), .load_ready(rl),
        .bit_en(bit_en), .serial_out(sol), .serial_valid(svl), .busy(bzl), .done(dnl));

    serial_bit_feeder #(.WIDTH(1), .MSB_FIRST(1)) dut1 (
        .clock(clock), .reset(reset), .load_data(ld1), .load_valid(lv1), .load_ready(r1),
        .bit_en(bit_en), .serial_out(so1), .serial_valid(sv1), .busy(bz1), .done(dn1));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL reset_w8 got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
        n_cmp++;
        if ({sol, svl, bzl, rl, dnl} !== 5'b00010) begin
            n_err++; $display("FAIL reset_lsb got=%b exp=%b", {sol, svl, bzl, rl, dnl}, 5'b00010);
        end
        n_cmp++;
        if ({so1, sv1, bz1, r1, dn1} !== 5'b00010) begin
            n_err++; $display("FAIL reset_w1 got=%b exp=%b", {so1, sv1, bz1, r1, dn1}, 5'b00010);
        end
        tick();
        tick();
        reset = 1'b0;
        bit_en = 1'b1;
        tick();
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL idle_bit_en got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w = 8'b1011_0010;
        bit_en = 1'b1;
        ld8 = w; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {w[7-i], 4'b1100}) begin
                n_err++; $display("FAIL msb_bit%0d got=%b exp=%b", i, {so8, sv8, bz8, r8, dn8}, {w[7-i], 4'b1100});
            end
            tick();
        end
`ifdef SBF_PARITY_EN
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== {^w, 4'b1100}) begin
            n_err++; $display("FAIL msb_parity got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, {^w, 4'b1100});
        end
        tick();
`endif
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00001) begin
            n_err++; $display("FAIL msb_done got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00001);
        end
        tick();
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL msb_idle got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w = 8'h01;
        bit_en = 1'b1;
        ldl = w; lvl = 1'b1;
        tick();
        lvl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({sol, svl, bzl, rl, dnl} !== {w[i], 4'b1100}) begin
                n_err++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, {sol, svl, bzl, rl, dnl}, {w[i], 4'b1100});
            end
            tick();
        end
`ifdef SBF_PARITY_EN
        n_cmp++;
        if ({sol, svl, bzl, rl, dnl} !== {^w, 4'b1100}) begin
            n_err++; $display("FAIL lsb_parity got=%b exp=%b", {sol, svl, bzl, rl, dnl}, {^w, 4'b1100});
        end
        tick();
`endif
        n_cmp++;
        if ({sol, svl, bzl, rl, dnl} !== 5'b00001) begin
            n_err++; $display("FAIL lsb_done got=%b exp=%b", {sol, svl, bzl, rl, dnl}, 5'b00001);
        end
        tick();
    endtask

    task automatic test_bit_en_toggle();
        logic [7:0] w = 8'hF0;
        int k = 0;
        int c = 0;
        ld8 = w; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        // Strobe every third cycle; serial_out must stay on bit k between strobes.
        while (k < 8 && c < 100) begin
            bit_en = (c % 3 == 0);
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {w[7-k], 4'b1100}) begin
                n_err++; $display("FAIL pace_c%0d got=%b exp=%b", c, {so8, sv8, bz8, r8, dn8}, {w[7-k], 4'b1100});
            end
            if (bit_en) k++;
            tick();
            c++;
        end
`ifdef SBF_PARITY_EN
        do begin
            bit_en = (c % 3 == 0);
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {^w, 4'b1100}) begin
                n_err++; $display("FAIL pace_parity got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, {^w, 4'b1100});
            end
            tick();
            c++;
        end while ((c - 1) % 3 != 0);
`endif
        bit_en = 1'b1;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00001) begin
            n_err++; $display("FAIL pace_done got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00001);
        end
        tick();
    endtask

    task automatic test_ignore_load();
        logic [7:0] w = 8'h3C;
        bool_drain: begin end
        bit_en = 1'b1;
        ld8 = w; lv8 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            ld8 = ~w ^ 8'(i);
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {w[7-i], 4'b1100}) begin
                n_err++; $display("FAIL ign_bit%0d got=%b exp=%b", i, {so8, sv8, bz8, r8, dn8}, {w[7-i], 4'b1100});
            end
            tick();
        end
`ifdef SBF_PARITY_EN
        tick();
`endif
        ld8 = 8'hFF;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00001) begin
            n_err++; $display("FAIL ign_done got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00001);
        end
        tick();
        ld8 = 8'h81;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL ign_idle got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
        tick();
        lv8 = 1'b0;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b11100) begin
            n_err++; $display("FAIL ign_second got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b11100);
        end
        for (int i = 0; i < 20 && !dn8; i++) tick();
        n_cmp++;
        if (dn8 !== 1'b1) begin
            n_err++; $display("FAIL ign_drain got=%b exp=%b", dn8, 1'b1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] w = 8'hAA;
        logic [7:0] v = 8'h55;
        bit_en = 1'b1;
        ld8 = w; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {w[7-i], 4'b1100}) begin
                n_err++; $display("FAIL rst_bit%0d got=%b exp=%b", i, {so8, sv8, bz8, r8, dn8}, {w[7-i], 4'b1100});
            end
            tick();
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL rst_abort got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
            n_err++; $display("FAIL rst_nodone got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00010);
        end
        ld8 = v; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {v[7-i], 4'b1100}) begin
                n_err++; $display("FAIL rst_next%0d got=%b exp=%b", i, {so8, sv8, bz8, r8, dn8}, {v[7-i], 4'b1100});
            end
            tick();
        end
`ifdef SBF_PARITY_EN
        tick();
`endif
        n_cmp++;
        if ({so8, sv8, bz8, r8, dn8} !== 5'b00001) begin
            n_err++; $display("FAIL rst_next_done got=%b exp=%b", {so8, sv8, bz8, r8, dn8}, 5'b00001);
        end
        tick();
    endtask

    task automatic test_width1();
        ld1 = 1'b1; lv1 = 1'b1;
        bit_en = 1'b0;
        tick();
        lv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({so1, sv1, bz1, r1, dn1} !== 5'b11100) begin
                n_err++; $display("FAIL w1_hold%0d got=%b exp=%b", i, {so1, sv1, bz1, r1, dn1}, 5'b11100);
            end
            tick();
        end
        bit_en = 1'b1;
        tick();
`ifdef SBF_PARITY_EN
        n_cmp++;
        if ({so1, sv1, bz1, r1, dn1} !== 5'b11100) begin
            n_err++; $display("FAIL w1_parity got=%b exp=%b", {so1, sv1, bz1, r1, dn1}, 5'b11100);
        end
        tick();
`endif
        n_cmp++;
        if ({so1, sv1, bz1, r1, dn1} !== 5'b00001) begin
            n_err++; $display("FAIL w1_done got=%b exp=%b", {so1, sv1, bz1, r1, dn1}, 5'b00001);
        end
        tick();
        n_cmp++;
        if ({so1, sv1, bz1, r1, dn1} !== 5'b00010) begin
            n_err++; $display("FAIL w1_idle got=%b exp=%b", {so1, sv1, bz1, r1, dn1}, 5'b00010);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        bit_en = 1'b1;
        ld8 = 8'hC5; lv8 = 1'b1;
        tick();
        ld8 = 8'h3A;
        for (int n = 0; n < 2; n++) begin
            w = (n == 0) ? 8'hC5 : 8'h3A;
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if ({so8, sv8, bz8, r8, dn8} !== {w[7-i], 4'b1100}) begin
                    n_err++; $display("FAIL b2b_w%0d_bit%0d got=%b exp=%b", n, i, {so8, sv8, bz8, r8, dn8}, {w[7-i], 4'b1100});
                end
                tick();
            end
`ifdef SBF_PARITY_EN
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== {^w, 4'b1100}) begin
                n_err++; $display("FAIL b2b_w%0d_parity got=%b exp=%b", n, {so8, sv8, bz8, r8, dn8}, {^w, 4'b1100});
            end
            tick();
`endif
            if (n == 1) lv8 = 1'b0;
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== 5'b00001) begin
                n_err++; $display("FAIL b2b_w%0d_done got=%b exp=%b", n, {so8, sv8, bz8, r8, dn8}, 5'b00001);
            end
            tick();
            n_cmp++;
            if ({so8, sv8, bz8, r8, dn8} !== 5'b00010) begin
                n_err++; $display("FAIL b2b_w%0d_idle got=%b exp=%b", n, {so8, sv8, bz8, r8, dn8}, 5'b00010);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_bit_en_toggle();
        test_ignore_load();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
